fetch_stage: RTL and testbench

//  IF stage of the 5-stage pipelined MIPS core. Directly upstream of the IF/ID pipeline register.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_skid_buffer.sv | 43 ++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipelined MIPS core.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_HOLD,
        FS_HALTED
    } fetch_state_t;

endpackage : cpu_types_pkg

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction and its PC+4.
module fetch_skid_buffer
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] d_instr,
    input  logic [WORD_W-1:0] d_pc4,
    output logic              valid,
    output logic [WORD_W-1:0] q_instr,
    output logic [WORD_W-1:0] q_pc4
);

    logic              valid_q;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] pc4_q;

    // Capture on load; clear wins so a redirect/halt always drops the entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= d_instr;
            pc4_q   <= d_pc4;
        end
    end

    assign valid   = valid_q;
    assign q_instr = instr_q;
    assign q_pc4   = pc4_q;

endmodule : fetch_skid_buffer

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the imem read and feeds the IF/ID register.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned      WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic              ifid_enable_o,
    output logic              ifid_flush_o,
    output logic [WORD_W-1:0] instruction_o,
    output logic [WORD_W-1:0] PCplus4_o,
    output word_t             fetch_count_o
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    word_t             count_q, count_d;

    logic              buf_load;
    logic              buf_clear;
    logic              buf_valid;
    logic [WORD_W-1:0] buf_instr;
    logic [WORD_W-1:0] buf_pc4;

    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] redirect_target;
    logic              hold_sel;

    // Word-aligned arithmetic; both wrap modulo 2^WORD_W.
    assign pc_plus4        = pc_q + WORD_W'(WORD_BYTES);
    assign redirect_target = redirect_pc_i & ~WORD_W'(WORD_BYTES - 1);

    fetch_skid_buffer #(
        .WORD_W (WORD_W)
    ) u_skid (
        .CLK     (CLK),
        .nRST    (nRST),
        .load    (buf_load),
        .clear   (buf_clear),
        .d_instr (iload),
        .d_pc4   (pc_plus4),
        .valid   (buf_valid),
        .q_instr (buf_instr),
        .q_pc4   (buf_pc4)
    );

    // State, PC and delivered-instruction counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FS_RUN;
            pc_q    <= PC_INIT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Next state and IF/ID controls; priority halt > redirect > stall > ihit.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        ifid_enable_o = 1'b0;
        ifid_flush_o  = 1'b0;

        // Outputs are gated by nRST so they sit at reset values while it is low.
        if (!nRST || state_q == FS_HALTED) begin
            state_d = state_q;
        end else if (halt_i) begin
            state_d   = FS_HALTED;
            buf_clear = 1'b1;
        end else if (redirect_i) begin
            ifid_flush_o = 1'b1;
            pc_d         = redirect_target;
            buf_clear    = 1'b1;
            state_d      = FS_RUN;
        end else begin
            unique case (state_q)
                FS_RUN: begin
                    if (ihit) begin
                        pc_d = pc_plus4;
                        if (stall_i) begin
                            buf_load = 1'b1;
                            state_d  = FS_HOLD;
                        end else begin
                            ifid_enable_o = 1'b1;
                            count_d       = count_q + 32'd1;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall_i) begin
                        ifid_enable_o = 1'b1;
                        buf_clear     = 1'b1;
                        state_d       = FS_RUN;
                        count_d       = count_q + 32'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath to IF/ID: buffered word in HOLD, otherwise the live imem word.
    assign hold_sel      = (state_q == FS_HOLD) && buf_valid;
    assign instruction_o = hold_sel ? buf_instr : (nRST ? iload : '0);
    assign PCplus4_o     = hold_sel ? buf_pc4 : pc_plus4;
    assign imemREN       = (state_q == FS_RUN);
    assign imemaddr      = pc_q;
    assign fetch_count_o = count_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected IF/ID words,
// a negedge monitor pops them whenever the stage asserts ifid_enable_o.
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        ifid_enable_o;
    logic        ifid_flush_o;
    logic [31:0] instruction_o;
    logic [31:0] PCplus4_o;
    logic [31:0] fetch_count_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] exp_q[$];

    fetch_stage dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .iload         (iload),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .ifid_enable_o (ifid_enable_o),
        .ifid_flush_o  (ifid_flush_o),
        .instruction_o (instruction_o),
        .PCplus4_o     (PCplus4_o),
        .fetch_count_o (fetch_count_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic hit, input logic [31:0] word, input logic stall,
                         input logic redir, input logic [31:0] rpc, input logic halt);
        ihit          = hit;
        iload         = word;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        halt_i        = halt;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc4);
        exp_q.push_back({instr, pc4});
    endtask

    // Monitor: every IF/ID load must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (nRST && ifid_enable_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ifid_unexpected: got instr %h pc4 %h want no load", instruction_o, PCplus4_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({instruction_o, PCplus4_o} !== e) begin
                    errors++;
                    $display("FAIL ifid_word: got %h/%h want %h/%h",
                             instruction_o, PCplus4_o, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset values, including with a pending ihit during reset.
        step();
        drive(1'b1, 32'h2001_0005, 1'b0, 1'b1, 32'h40, 1'b0);
        #1;
        chk("rst_ren", 32'(imemREN), 32'd1);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_en", 32'(ifid_enable_o), 32'd0);
        chk("rst_flush", 32'(ifid_flush_o), 32'd0);
        chk("rst_instr", instruction_o, 32'h0);
        chk("rst_pc4", PCplus4_o, 32'h4);
        chk("rst_count", fetch_count_o, 32'h0);
        step();
        nRST = 1'b1;

        // Streaming fetch with ihit every cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0, 1'b0);
            expect_word(32'h2001_0005, 32'(4 * (k + 1)));
            #1;
            chk("run_addr", imemaddr, 32'(4 * k));
            chk("run_ren", 32'(imemREN), 32'd1);
            chk("run_count", fetch_count_o, 32'(k));
            step();
        end

        // Stall with ihit at pc=0x10: word captured, then released.
        drive(1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("stall_addr", imemaddr, 32'h10);
        chk("stall_en", 32'(ifid_enable_o), 32'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            chk("hold_ren", 32'(imemREN), 32'd0);
            chk("hold_en", 32'(ifid_enable_o), 32'd0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_word(32'hAAAA_0001, 32'h14);
        #1;
        chk("release_en", 32'(ifid_enable_o), 32'd1);
        step();
        chk("release_addr", imemaddr, 32'h14);
        chk("release_ren", 32'(imemREN), 32'd1);
        chk("release_count", fetch_count_o, 32'd5);

        // Redirect with a same-cycle ihit: flushed, word discarded.
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h40, 1'b0);
        #1;
        chk("redir_flush", 32'(ifid_flush_o), 32'd1);
        chk("redir_en", 32'(ifid_enable_o), 32'd0);
        step();
        chk("redir_addr", imemaddr, 32'h40);
        chk("redir_count", fetch_count_o, 32'd5);

        // Redirect while holding (unaligned target): buffer dropped.
        drive(1'b1, 32'h1111_2222, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0083, 1'b0);
        #1;
        chk("hold_redir_flush", 32'(ifid_flush_o), 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("hold_redir_en", 32'(ifid_enable_o), 32'd0);
        chk("hold_redir_addr", imemaddr, 32'h80);
        chk("hold_redir_ren", 32'(imemREN), 32'd1);
        step();

        // PC wrap at the top of the address space.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step();
        drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_word(32'h0BAD_F00D, 32'h0);
        #1;
        chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCplus4_o, 32'h0);
        step();
        chk("wrap_next_addr", imemaddr, 32'h0);
        chk("wrap_count", fetch_count_o, 32'd6);

        // One more fetch, then halt beats a same-cycle redirect.
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_word(32'h1234_5678, 32'h4);
        step();
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h100, 1'b1);
        #1;
        chk("halt_flush", 32'(ifid_flush_o), 32'd0);
        chk("halt_en", 32'(ifid_enable_o), 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h5555_5555, 1'b0, 1'(k % 2), 32'h100, 1'b0);
            #1;
            chk("halted_ren", 32'(imemREN), 32'd0);
            chk("halted_flush", 32'(ifid_flush_o), 32'd0);
            chk("halted_addr", imemaddr, 32'h4);
            step();
        end
        chk("halted_count", fetch_count_o, 32'd7);

        // Asynchronous reset pulse with ihit and redirect pending.
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h100, 1'b0);
        #1;
        nRST = 1'b0;
        #1;
        chk("arst_ren", 32'(imemREN), 32'd1);
        chk("arst_addr", imemaddr, 32'h0);
        chk("arst_en", 32'(ifid_enable_o), 32'd0);
        chk("arst_flush", 32'(ifid_flush_o), 32'd0);
        chk("arst_instr", instruction_o, 32'h0);
        chk("arst_pc4", PCplus4_o, 32'h4);
        chk("arst_count", fetch_count_o, 32'h0);
        step();
        nRST = 1'b1;
        drive(1'b1, 32'h3C00_0001, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_word(32'h3C00_0001, 32'h4);
        #1;
        chk("restart_addr", imemaddr, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("restart_count", fetch_count_o, 32'd1);
        step();
        step();

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
